// File: rtl/canvas_port_arbiter.sv
// canvas_port_arbiter: shares the small_canvas a/d/we/spo port between the clear sweep,
// recognizer reads and mouse writes (priority in that order); the port itself is registered.
module canvas_port_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m_req,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic              m_data,
   output logic              m_gnt,
   input  logic              r_lock,
   input  logic              r_req,
   input  logic [ADDR_W-1:0] r_addr,
   output logic              r_gnt,
   output logic              r_valid,
   output logic              r_data,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] cv_a,
   output logic              cv_d,
   output logic              cv_we,
   input  logic              cv_spo
);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t            state;
   logic [ADDR_W:0]   cnt;
   logic              pend, rd_pend, idle, clear_go;
   assign idle     = ~rst & (state == IDLE);
   assign clear_go = idle & (clr_start | pend) & ~r_lock;
   assign r_gnt    = idle & r_req & ~clear_go;
   assign m_gnt    = idle & m_req & ~r_lock & ~r_req & ~clear_go;
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         pend     <= 1'b0;
         rd_pend  <= 1'b0;
         r_valid  <= 1'b0;
         r_data   <= 1'b0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
         cv_a     <= '0;
         cv_d     <= 1'b0;
         cv_we    <= 1'b0;
      end else begin
         // read data is sampled while cv_a still holds the granted address
         rd_pend  <= r_gnt;
         r_valid  <= rd_pend;
         if (rd_pend) r_data <= cv_spo;
         clr_done <= 1'b0;
         cv_we    <= 1'b0;
         if (state == CLEAR) begin
            cv_a  <= cnt[ADDR_W-1:0];
            cv_d  <= 1'b0;
            cv_we <= 1'b1;
            cnt   <= cnt + 1'b1;
            if (cnt == (ADDR_W+1)'(DEPTH-1)) begin
               state    <= IDLE;
               clr_done <= 1'b1;
               clr_busy <= pend;
            end
         end else if (clear_go) begin
            state    <= CLEAR;
            cnt      <= '0;
            pend     <= 1'b0;
            clr_busy <= 1'b1;
         end else begin
            pend     <= pend | (clr_start & r_lock);
            clr_busy <= pend | (clr_start & r_lock);
            if (r_gnt) cv_a <= r_addr;
            else if (m_gnt) begin
               cv_a  <= m_addr;
               cv_d  <= m_data;
               cv_we <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_canvas_port_arbiter.sv
// tb_canvas_port_arbiter: scoreboard bench with a canvas emulator and a behavioural model
// of grants, sweep progress and expected port/read traffic.
module tb_canvas_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1, clr_start = 1'b0, r_lock = 1'b0, r_req = 1'b0, m_req = 1'b0, m_data = 1'b0;
   logic [9:0] r_addr = '0, m_addr = '0;
   logic m_gnt, r_gnt, r_valid, r_data, clr_busy, clr_done, cv_d, cv_we, cv_spo;
   logic [9:0] cv_a;

   canvas_port_arbiter #(.ADDR_W(10), .DEPTH(1024)) dut (
      .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_data(m_data), .m_gnt(m_gnt),
      .r_lock(r_lock), .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt), .r_valid(r_valid),
      .r_data(r_data), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
      .cv_a(cv_a), .cv_d(cv_d), .cv_we(cv_we), .cv_spo(cv_spo));

   always #5 clk = ~clk;

   // canvas emulator: write on the clock, asynchronous read
   logic mem_dut [1024];
   always @(posedge clk) if (cv_we) mem_dut[cv_a] <= cv_d;
   assign cv_spo = mem_dut[cv_a];

   typedef struct {int t; logic [9:0] a; logic d;} wr_t;
   typedef struct {int t; logic d;} rd_t;
   wr_t wq[$];
   rd_t rq[$];
   logic ref_mem [1024];
   int cyc = 0, checks = 0, failures = 0;
   int sweep_left = 0;
   bit pend = 0, on = 0;
   bit exp_m = 0, exp_r = 0, cur_busy = 0, cur_done = 0, nxt_busy = 0, nxt_done = 0;
   bit i_mr = 0, i_md = 0, i_rr = 0, i_rl = 0;
   logic [9:0] i_ma = '0, i_ra = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, act, exp);
      end
   endtask

   task automatic flag(input string n);
      checks++;
      failures++;
      $display("FAIL %s cyc=%0d", n, cyc);
   endtask

   // one clock of stimulus; the model decides grants, sweep writes and expected port traffic
   task automatic tick(input bit rs, input bit cs);
      wr_t tw[$];
      rd_t tr[$];
      bit idle, go;
      int a;
      @(posedge clk);
      #1;
      rst = rs; clr_start = cs; r_lock = i_rl;
      m_req = i_mr; m_addr = i_ma; m_data = i_md;
      r_req = i_rr; r_addr = i_ra;
      cur_busy = nxt_busy;
      cur_done = nxt_done;
      if (rs) begin
         exp_m = 0; exp_r = 0; sweep_left = 0; pend = 0; nxt_busy = 0; nxt_done = 0;
         tw = wq; wq.delete();
         foreach (tw[i]) if (tw[i].t <= cyc) wq.push_back(tw[i]);
         tr = rq; rq.delete();
         foreach (tr[i]) if (tr[i].t <= cyc) rq.push_back(tr[i]);
      end else begin
         idle = (sweep_left == 0);
         go = idle && (cs || pend) && !i_rl;
         exp_r = idle && i_rr && !go;
         exp_m = idle && i_mr && !i_rl && !i_rr && !go;
         nxt_done = 0;
         if (!idle) begin
            a = 1024 - sweep_left;
            wq.push_back('{cyc + 1, 10'(a), 1'b0});
            ref_mem[a] = 1'b0;
            sweep_left--;
            if (sweep_left == 0) nxt_done = 1;
         end else if (go) begin
            sweep_left = 1024;
            pend = 0;
         end else if (cs && i_rl) pend = 1;
         if (exp_m) begin
            wq.push_back('{cyc + 1, i_ma, i_md});
            ref_mem[i_ma] = i_md;
         end
         if (exp_r) rq.push_back('{cyc + 2, ref_mem[i_ra]});
         nxt_busy = pend || (sweep_left > 0);
      end
      @(negedge clk);
      #1;
      if (exp_m) i_mr = 0;
      if (exp_r) i_rr = 0;
   endtask

   always @(negedge clk) if (on) begin
      wr_t w;
      rd_t r;
      chk("m_gnt", m_gnt, exp_m);
      chk("r_gnt", r_gnt, exp_r);
      chk("clr_busy", clr_busy, cur_busy);
      chk("clr_done", clr_done, cur_done);
      while (wq.size() != 0 && wq[0].t < cyc) begin
         void'(wq.pop_front());
         flag("wr_missing");
      end
      while (rq.size() != 0 && rq[0].t < cyc) begin
         void'(rq.pop_front());
         flag("rd_missing");
      end
      if (cv_we) begin
         if (wq.size() == 0) flag("wr_unexpected");
         else begin
            w = wq.pop_front();
            chk("wr_time", cyc, w.t);
            chk("wr_addr", cv_a, w.a);
            chk("wr_data", cv_d, w.d);
         end
      end
      if (r_valid) begin
         if (rq.size() == 0) flag("rd_unexpected");
         else begin
            r = rq.pop_front();
            chk("rd_time", cyc, r.t);
            chk("rd_data", r_data, r.d);
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ref_mem[i] = 1'($urandom);
         mem_dut[i] = ref_mem[i];
      end
      tick(1, 0);
      tick(1, 0);
      chk("rst_cv_a", cv_a, 0);
      chk("rst_cv_d", cv_d, 0);
      chk("rst_cv_we", cv_we, 0);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_r_data", r_data, 0);
      chk("rst_clr_busy", clr_busy, 0);
      chk("rst_clr_done", clr_done, 0);
      chk("rst_grants", {m_gnt, r_gnt}, 0);
      on = 1;
      // mouse write 0x155 and 0x3FF
      i_mr = 1; i_ma = 10'h155; i_md = 1;
      tick(0, 0);
      i_mr = 1; i_ma = 10'h3FF; i_md = 1;
      tick(0, 0);
      tick(0, 0);
      // read beats mouse under r_lock
      i_rl = 1; i_rr = 1; i_ra = 10'h3FF; i_mr = 1; i_ma = 10'h010; i_md = 0;
      for (int k = 0; k < 4; k++) tick(0, 0);
      i_rl = 0;
      for (int k = 0; k < 3; k++) tick(0, 0);
      // clear with mouse held
      i_mr = 1; i_ma = 10'h2AA; i_md = 1;
      tick(0, 1);
      for (int k = 0; k < 1100 && (sweep_left != 0 || i_mr); k++) tick(0, 0);
      // clear requested under r_lock
      i_rl = 1;
      tick(0, 1);
      for (int k = 0; k < 5; k++) tick(0, 0);
      i_rl = 0;
      for (int k = 0; k < 1100 && (sweep_left != 0 || pend); k++) tick(0, 0);
      // back-to-back reads
      i_mr = 1; i_ma = 10'd1; i_md = 1;
      tick(0, 0);
      for (int k = 0; k < 3; k++) begin
         i_rr = 1; i_ra = 10'(k);
         tick(0, 0);
      end
      for (int k = 0; k < 3; k++) tick(0, 0);
      // random traffic
      for (int n = 0; n < 2500; n++) begin
         if (!i_mr && $urandom % 3 == 0) begin
            i_mr = 1; i_ma = 10'($urandom); i_md = 1'($urandom);
         end
         if (!i_rr && $urandom % 4 == 0) begin
            i_rr = 1; i_ra = 10'($urandom);
         end
         if ($urandom % 16 == 0) i_rl = !i_rl;
         tick(0, $urandom % 400 == 0);
      end
      i_rl = 0; i_mr = 0; i_rr = 0;
      for (int k = 0; k < 1100 && (sweep_left != 0 || pend); k++) tick(0, 0);
      // reset at sweep address 500
      tick(0, 1);
      for (int k = 0; k < 1100 && sweep_left != 524; k++) tick(0, 0);
      tick(1, 0);
      for (int k = 0; k < 5; k++) tick(0, 0);
      tick(0, 1);
      for (int k = 0; k < 1100 && sweep_left != 0; k++) tick(0, 0);
      for (int k = 0; k < 4; k++) begin
         i_rr = 1; i_ra = 10'($urandom);
         tick(0, 0);
      end
      for (int k = 0; k < 5; k++) tick(0, 0);
      chk("wq_drained", wq.size(), 0);
      chk("rq_drained", rq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
